// File: rtl/sectorbuf_streamer_pkg.sv
// Shared disk-path definitions: sector geometry and the streamer FSM state encoding.
package sectorbuf_streamer_pkg;

    localparam int SECTOR_WORDS = 256;
    localparam int SECTOR_AW    = 8;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_REQ  = 4'd1,
        ST_RD_WAIT = 4'd2,
        ST_TX_LO   = 4'd3,
        ST_TX_HI   = 4'd4,
        ST_RX_LO   = 4'd5,
        ST_RX_HI   = 4'd6,
        ST_WR      = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

endpackage

// File: rtl/sectorbuf_streamer.sv
// Port-B master of the sector buffer: streams one sector between 16-bit buffer words
// and an 8-bit byte stream, low byte first.
module sectorbuf_streamer
    import sectorbuf_streamer_pkg::*;
#(
    parameter int WORDS = SECTOR_WORDS,
    parameter int AW    = SECTOR_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          dir,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] addr_b,
    output logic [15:0]   data_b,
    output logic          wren_b,
    input  logic [15:0]   q_b,
    output logic [7:0]    tx_data,
    output logic          tx_valid,
    input  logic          tx_ready,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready
);

    localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_hi;
    logic [7:0] lo;
    logic       tx_hs;
    logic       rx_hs;
    logic       at_last;

    // Handshakes are qualified by state, so ready/valid never reach an output combinationally.
    assign tx_hs   = ((state == ST_TX_LO) || (state == ST_TX_HI)) && tx_ready;
    assign rx_hs   = ((state == ST_RX_LO) || (state == ST_RX_HI)) && rx_valid;
    assign at_last = (addr_b == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start) state_nxt = dir ? ST_RX_LO : ST_RD_REQ;
                ST_RD_REQ:  state_nxt = ST_RD_WAIT;
                ST_RD_WAIT: state_nxt = ST_TX_LO;
                ST_TX_LO:   if (tx_hs) state_nxt = ST_TX_HI;
                ST_TX_HI:   if (tx_hs) state_nxt = at_last ? ST_DONE : ST_RD_REQ;
                ST_RX_LO:   if (rx_hs) state_nxt = ST_RX_HI;
                ST_RX_HI:   if (rx_hs) state_nxt = ST_WR;
                ST_WR:      state_nxt = at_last ? ST_DONE : ST_RX_LO;
                ST_DONE:    state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state != ST_IDLE) && (state != ST_DONE);
        done     = (state == ST_DONE);
        tx_valid = (state == ST_TX_LO) || (state == ST_TX_HI);
        rx_ready = (state == ST_RX_LO) || (state == ST_RX_HI);
        wren_b   = (state == ST_WR);
    end

    // Address counter and byte/word assembly registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_b  <= '0;
            data_b  <= '0;
            tx_data <= '0;
            hold_hi <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) addr_b <= '0;
                end
                ST_RD_WAIT: begin
                    hold_hi <= q_b[15:8];
                    tx_data <= q_b[7:0];
                end
                ST_TX_LO: begin
                    if (tx_hs) tx_data <= hold_hi;
                end
                ST_TX_HI: begin
                    if (tx_hs && !at_last) addr_b <= addr_b + 1'b1;
                end
                ST_RX_LO: begin
                    if (rx_hs) lo <= rx_data;
                end
                ST_RX_HI: begin
                    if (rx_hs) data_b <= {rx_data, lo};
                end
                ST_WR: begin
                    if (!at_last) addr_b <= addr_b + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
